// File: rtl/dglk_spi_master_if.sv
// Bus bundle for dglk_spi_master: RTMQ ALU write bus in, register readback and SPI pins out.
// Handshake: there is no valid/ready pair. alu_out is sampled on every clk and a write lands when its
// address field matches a register. f_spi_done is a one-cycle strobe with no back-pressure.
interface dglk_spi_master_if #(
    parameter int W_REG = 32,
    parameter int W_ADR = 8,
    parameter int W_ALU = 3*W_REG + 4*W_ADR + 1
);
    logic [W_ALU-1:0] alu_out;
    logic [W_REG-1:0] reg_sdat;
    logic [W_REG-1:0] reg_sctl;
    logic [2:0]       slv_adr;
    logic             f_spi_done;
    logic             csb;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic [1:0]       dbg_state;

    modport master (
        input  alu_out, miso,
        output reg_sdat, reg_sctl, slv_adr, f_spi_done, csb, sclk, mosi, dbg_state
    );

    modport slave (
        output alu_out, miso,
        input  reg_sdat, reg_sctl, slv_adr, f_spi_done, csb, sclk, mosi, dbg_state
    );
endinterface

// File: rtl/dglk_spi_master.sv
// RTMQ bus-mapped SPI master: SDAT/SCTL registers; an SCTL write starts a 1..32 bit MSB-first transfer.
// Optional macro SPI_MODE_SEL_EN enables CPOL (SCTL[19]) and CPHA (SCTL[20]); otherwise mode 0 is fixed.
module dglk_spi_master #(
    parameter int               W_REG = 32,
    parameter int               W_ADR = 8,
    parameter int               W_ALU = 3*W_REG + 4*W_ADR + 1,
    parameter logic [W_ADR-1:0] R_SDA = 8'h20,
    parameter logic [W_ADR-1:0] R_SCT = 8'h21
) (
    input logic               clk,
    input logic               rst_n,
    dglk_spi_master_if.master bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;

    state_t           state;
    logic [W_REG-1:0] sdat_q, sctl_q;
    logic             csb_q, sclk_q, mosi_q, done_q;
    logic [7:0]       cnt_q;
    logic [5:0]       edg_q;

    logic [W_REG-1:0] alu_res, alu_msk, imm_res;
    logic [W_ADR-1:0] alu_rda, imm_rda;
    logic             imm_seg;
    logic             unused_adr;

    // alu_out = {alu_res, alu_msk, alu_rda, alu_r0a, alu_r1a, imm_res, imm_rda, imm_seg}
    assign alu_res    = bus.alu_out[2*W_REG+4*W_ADR+1 +: W_REG];
    assign alu_msk    = bus.alu_out[W_REG+4*W_ADR+1 +: W_REG];
    assign alu_rda    = bus.alu_out[W_REG+3*W_ADR+1 +: W_ADR];
    assign imm_res    = bus.alu_out[W_ADR+1 +: W_REG];
    assign imm_rda    = bus.alu_out[1 +: W_ADR];
    assign imm_seg    = bus.alu_out[0];
    assign unused_adr = ^bus.alu_out[W_REG+W_ADR+1 +: 2*W_ADR];

    logic [W_REG-1:0] sdat_wr, sctl_wr;
    logic             sct_hit;

    // ALU write takes priority over an immediate write to the same register.
    always_comb begin
        sdat_wr = sdat_q;
        sctl_wr = sctl_q;
        if (alu_rda == R_SDA)
            sdat_wr = (sdat_q & ~alu_msk) | (alu_res & alu_msk);
        else if (imm_rda == R_SDA)
            sdat_wr = imm_seg ? {imm_res[W_REG-1:W_REG/2], sdat_q[W_REG/2-1:0]} : imm_res;
        if (alu_rda == R_SCT)
            sctl_wr = (sctl_q & ~alu_msk) | (alu_res & alu_msk);
        else if (imm_rda == R_SCT)
            sctl_wr = imm_seg ? {imm_res[W_REG-1:W_REG/2], sctl_q[W_REG/2-1:0]} : imm_res;
        sct_hit = (alu_rda == R_SCT) || (imm_rda == R_SCT);
    end

    function automatic logic [5:0] bit_count(input logic [5:0] f);
        return (f == 6'd0 || f > 6'd32) ? 6'd32 : f;
    endfunction

    logic [5:0] n_cur, n_new;
    logic [4:0] idx_cur, idx_new;
    logic [6:0] last_edge;
    logic       cpol, cpha, cpol_wr;

    assign n_cur     = bit_count(sctl_q[5:0]);
    assign n_new     = bit_count(sctl_wr[5:0]);
    assign idx_cur   = 5'(n_cur - 6'd1);
    assign idx_new   = 5'(n_new - 6'd1);
    assign last_edge = {n_cur, 1'b0} - 7'd1;

`ifdef SPI_MODE_SEL_EN
    assign cpol    = sctl_q[19];
    assign cpha    = sctl_q[20];
    assign cpol_wr = sctl_wr[19];
`else
    assign cpol    = 1'b0;
    assign cpha    = 1'b0;
    assign cpol_wr = 1'b0;
`endif

    // edg_q counts sclk half-periods; even = leading edge, odd = trailing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sdat_q <= '0;
            sctl_q <= '0;
            csb_q  <= 1'b1;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            edg_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    sdat_q <= sdat_wr;
                    sctl_q <= sctl_wr;
                    sclk_q <= cpol_wr;
                    if (sct_hit) begin
                        state  <= S_SHIFT;
                        csb_q  <= 1'b0;
                        mosi_q <= sdat_wr[idx_new];
                        cnt_q  <= '0;
                        edg_q  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q != sctl_q[15:8]) begin
                        cnt_q <= cnt_q + 8'd1;
                    end else begin
                        cnt_q <= '0;
                        edg_q <= edg_q + 6'd1;
                        if (!edg_q[0]) begin
                            sclk_q <= ~cpol;
                            if (cpha) mosi_q <= sdat_q[idx_cur];
                            else      sdat_q <= {sdat_q[W_REG-2:0], bus.miso};
                        end else begin
                            sclk_q <= cpol;
                            if (cpha) sdat_q <= {sdat_q[W_REG-2:0], bus.miso};
                            else      mosi_q <= sdat_q[idx_cur];
                            if ({1'b0, edg_q} == last_edge) begin
                                state  <= S_IDLE;
                                csb_q  <= 1'b1;
                                mosi_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.reg_sdat   = sdat_q;
    assign bus.reg_sctl   = {state == S_SHIFT, sctl_q[W_REG-2:0]};
    assign bus.slv_adr    = sctl_q[18:16];
    assign bus.f_spi_done = done_q;
    assign bus.csb        = csb_q;
    assign bus.sclk       = sclk_q;
    assign bus.mosi       = mosi_q;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_dglk_spi_master.sv
// Scoreboard bench for dglk_spi_master (default mode-0 build): driver pushes expectations,
// a negedge monitor checks pin timing and pops results on each f_spi_done.
module tb_dglk_spi_master;
    localparam logic [7:0] R_SDA = 8'h20;
    localparam logic [7:0] R_SCT = 8'h21;

    typedef struct {
        logic [31:0] sdat0;
        int          n;
        int          h;
        logic [2:0]  slv;
    } xfer_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] miso_mode;
    int         checks = 0;
    int         failures = 0;

    logic [31:0] exp_q[$];
    xfer_t       cfg_q[$];

    logic [31:0] m_sdat, m_sctl, m_final;
    logic        m_busy;
    int          m_n, m_h;

    dglk_spi_master_if bus();

    dglk_spi_master dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / miso source
    always #5 clk = ~clk;

    assign bus.miso = (miso_mode == 2'd0) ? 1'b0 :
                      (miso_mode == 2'd1) ? 1'b1 :
                      (miso_mode == 2'd2) ? bus.mosi : ~bus.mosi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // reference model: outcome of a transfer from the starting SDAT/SCTL and the miso source
    task automatic model_start();
        logic [63:0] wide, mask, rx;
        xfer_t       x;
        m_n  = (m_sctl[5:0] == 6'd0 || m_sctl[5:0] > 6'd32) ? 32 : int'(m_sctl[5:0]);
        m_h  = int'(m_sctl[15:8]) + 1;
        wide = {32'd0, m_sdat} << m_n;
        mask = (64'd1 << m_n) - 64'd1;
        case (miso_mode)
            2'd0:    rx = 64'd0;
            2'd1:    rx = mask;
            2'd2:    rx = {32'd0, m_sdat} & mask;
            default: rx = ~{32'd0, m_sdat} & mask;
        endcase
        m_final = wide[31:0] | rx[31:0];
        x.sdat0 = m_sdat;
        x.n     = m_n;
        x.h     = m_h;
        x.slv   = m_sctl[18:16];
        cfg_q.push_back(x);
        exp_q.push_back(m_final);
        m_busy = 1'b1;
    endtask

    // driver tasks
    task automatic drive_bus(input logic [31:0] a_res, input logic [31:0] a_msk, input logic [7:0] a_rda,
                             input logic [31:0] i_res, input logic [7:0] i_rda, input logic i_seg);
        logic [31:0] nsd, nsc;
        @(posedge clk); #1;
        bus.alu_out = {a_res, a_msk, a_rda, 8'h00, 8'h00, i_res, i_rda, i_seg};
        if (!m_busy) begin
            nsd = m_sdat;
            nsc = m_sctl;
            if (a_rda == R_SDA)      nsd = (m_sdat & ~a_msk) | (a_res & a_msk);
            else if (i_rda == R_SDA) nsd = i_seg ? {i_res[31:16], m_sdat[15:0]} : i_res;
            if (a_rda == R_SCT)      nsc = (m_sctl & ~a_msk) | (a_res & a_msk);
            else if (i_rda == R_SCT) nsc = i_seg ? {i_res[31:16], m_sctl[15:0]} : i_res;
            m_sdat = nsd;
            m_sctl = nsc;
            if (a_rda == R_SCT || i_rda == R_SCT) model_start();
        end
        @(posedge clk); #1;
        bus.alu_out = '0;
    endtask

    task automatic alu_wr(input logic [7:0] adr, input logic [31:0] res, input logic [31:0] msk);
        drive_bus(res, msk, adr, 32'd0, 8'h00, 1'b0);
    endtask

    task automatic imm_wr(input logic [7:0] adr, input logic [31:0] val, input logic seg);
        drive_bus(32'd0, 32'd0, 8'h00, val, adr, seg);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.f_spi_done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout actual=none required=done_within_%0d_cycles", budget);
            cfg_q.delete();
            exp_q.delete();
        end
        m_sdat = m_final;
        m_busy = 1'b0;
        check("sctl_busy_after", 32'(bus.reg_sctl[31]), 32'd0);
        check("sctl_after", {1'b0, bus.reg_sctl[30:0]}, {1'b0, m_sctl[30:0]});
    endtask

    task automatic start_xfer(input logic [31:0] sdat, input logic [31:0] sctl);
        imm_wr(R_SDA, sdat, 1'b0);
        alu_wr(R_SCT, sctl, 32'hFFFF_FFFF);
        wait_done(2*m_n*m_h + 20);
    endtask

    task automatic abort_with_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_csb", 32'(bus.csb), 32'd1);
        check("rst_sclk", 32'(bus.sclk), 32'd0);
        check("rst_mosi", 32'(bus.mosi), 32'd0);
        check("rst_busy", 32'(bus.reg_sctl[31]), 32'd0);
        check("rst_sdat", bus.reg_sdat, 32'd0);
        check("rst_slv", 32'(bus.slv_adr), 32'd0);
        cfg_q.delete();
        exp_q.delete();
        m_sdat = 32'd0;
        m_sctl = 32'd0;
        m_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // monitor / scoreboard
    xfer_t cur;
    bit    in_x = 1'b0;
    logic  prev_sclk = 1'b0;
    int    low_cnt, bitk, hi_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_x      = 1'b0;
            prev_sclk = 1'b0;
        end else begin
            if (!in_x && !bus.csb) begin
                if (cfg_q.size() == 0) begin
                    check("csb_unexpected", 32'(bus.csb), 32'd1);
                end else begin
                    cur     = cfg_q[0];
                    in_x    = 1'b1;
                    low_cnt = 0;
                    bitk    = 0;
                    hi_w    = 0;
                    check("t0_slv_adr", 32'(bus.slv_adr), 32'(cur.slv));
                    check("t0_busy", 32'(bus.reg_sctl[31]), 32'd1);
                    check("t0_mosi", 32'(bus.mosi), 32'(cur.sdat0[cur.n-1]));
                end
            end
            if (in_x) begin
                if (!bus.csb) low_cnt++;
                if (bus.sclk && !prev_sclk) begin
                    if (bitk < cur.n) check("mosi_bit", 32'(bus.mosi), 32'(cur.sdat0[cur.n-1-bitk]));
                    bitk++;
                    hi_w = 1;
                end else if (bus.sclk) begin
                    hi_w++;
                end
                if (!bus.sclk && prev_sclk) check("sclk_high", 32'(hi_w), 32'(cur.h));
            end
            if (bus.f_spi_done) begin
                if (!in_x || exp_q.size() == 0) begin
                    check("done_unexpected", 32'(bus.f_spi_done), 32'd0);
                end else begin
                    check("rx_sdat", bus.reg_sdat, exp_q.pop_front());
                    void'(cfg_q.pop_front());
                    check("csb_low_cycles", 32'(low_cnt), 32'(2*cur.n*cur.h));
                    check("sclk_pulses", 32'(bitk), 32'(cur.n));
                    check("end_pins", {29'd0, bus.csb, bus.sclk, bus.mosi}, 32'd4);
                    in_x = 1'b0;
                end
            end
            prev_sclk = bus.sclk;
        end
    end

    // stimulus
    initial begin
        logic [31:0] sc, keep;
        rst_n       = 1'b0;
        miso_mode   = 2'd0;
        bus.alu_out = '0;
        m_sdat      = 32'd0;
        m_sctl      = 32'd0;
        m_final     = 32'd0;
        m_busy      = 1'b0;
        m_n         = 32;
        m_h         = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sdat", bus.reg_sdat, 32'd0);
        check("reset_sctl", bus.reg_sctl, 32'd0);
        check("reset_slv", 32'(bus.slv_adr), 32'd0);
        check("reset_pins", {28'd0, bus.csb, bus.sclk, bus.mosi, bus.f_spi_done}, 32'd8);
        rst_n = 1'b1;

        miso_mode = 2'd2;
        start_xfer(32'h0000_00A5, 32'h0000_0008);
        check("t1_loopback", 32'(bus.reg_sdat[7:0]), 32'h0000_00A5);

        miso_mode = 2'd0;
        start_xfer(32'h8000_0001, 32'h0000_0320);
        check("t2_zero", bus.reg_sdat, 32'd0);

        miso_mode = 2'd1;
        start_xfer(32'h0000_0000, 32'h0000_0104);
        check("t3_ones", bus.reg_sdat, 32'h0000_000F);

        // writes during a transfer are ignored
        miso_mode = 2'd3;
        imm_wr(R_SDA, 32'hC3C3_5A5A, 1'b0);
        alu_wr(R_SCT, 32'h0000_0210, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        imm_wr(R_SDA, 32'h0000_1234, 1'b0);
        check("t4_busy", 32'(bus.reg_sctl[31]), 32'd1);
        alu_wr(R_SCT, 32'h0000_0001, 32'hFFFF_FFFF);
        check("t4_sctl_kept", 32'(bus.reg_sctl[15:0]), 32'h0000_0210);
        wait_done(2*m_n*m_h + 20);

        // slave address from T0, then reset mid-transfer
        miso_mode = 2'd0;
        imm_wr(R_SDA, $urandom(), 1'b0);
        alu_wr(R_SCT, 32'h0005_0320, 32'hFFFF_FFFF);
        check("t5_slv_t0", 32'(bus.slv_adr), 32'd5);
        repeat (40) @(posedge clk);
        #1 check("t5_slv_mid", 32'(bus.slv_adr), 32'd5);
        abort_with_reset();
        repeat (30) @(posedge clk);
        #1 check("t5_csb_idle", 32'(bus.csb), 32'd1);

        // masked ALU write to SCTL touches only DIV
        miso_mode = 2'd2;
        start_xfer(32'h0000_00C3, 32'h0003_0002);
        alu_wr(R_SCT, 32'hFFFF_FFFF, 32'h0000_FF00);
        check("t6_div", 32'(bus.reg_sctl[15:8]), 32'h0000_00FF);
        check("t6_sctl", bus.reg_sctl, {1'b1, m_sctl[30:0]});
        wait_done(2*m_n*m_h + 20);

        keep = m_sdat;
        imm_wr(R_SDA, 32'hABCD_1234, 1'b1);
        check("t6_seg_lo", 32'(bus.reg_sdat[15:0]), 32'(keep[15:0]));
        check("t6_seg_hi", 32'(bus.reg_sdat[31:16]), 32'h0000_ABCD);
        drive_bus(32'h1111_2222, 32'hFFFF_FFFF, R_SDA, 32'h9999_8888, R_SDA, 1'b0);
        check("alu_wins", bus.reg_sdat, 32'h1111_2222);
        drive_bus(32'h0000_00FF, 32'h0000_00F0, R_SDA, 32'h7777_7777, R_SDA, 1'b0);
        check("alu_mask", bus.reg_sdat, m_sdat);

        for (int it = 0; it < 12; it++) begin
            miso_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) imm_wr(R_SDA, $urandom(), 1'($urandom_range(0, 1)));
            else                           alu_wr(R_SDA, $urandom(), $urandom());
            sc        = $urandom();
            sc[15:8]  = 8'($urandom_range(0, 3));
            sc[20:19] = 2'b00;
            if ($urandom_range(0, 3) == 0) imm_wr(R_SCT, sc, 1'b0);
            else                           alu_wr(R_SCT, sc, 32'hFFFF_FFFF);
            wait_done(2*m_n*m_h + 20);
        end

        repeat (5) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
